// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter, issues single-cycle fetch
// requests, captures the returned word one cycle after completion and
// presents it to decode over a valid/ready handshake. Branch redirects
// squash in-flight or held words; a fetch that never completes trips a
// sticky fault that only reset clears.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned PC_STEP       = 4,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_run,
  output logic        o_fetch_enable,
  output logic [31:0] o_fetch_pc,
  input  logic [31:0] i_fetch_instruction,
  input  logic        i_fetch_completed,
  output logic        o_ir_valid,
  output logic [31:0] o_ir,
  output logic [31:0] o_ir_pc,
  input  logic        i_ir_ready,
  input  logic        i_branch_valid,
  input  logic [31:0] i_branch_target,
  output logic        o_busy,
  output logic        o_fault
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_HOLD    = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  // The counter holds the number of WAIT cycles already spent, so the last
  // allowed WAIT cycle is the one where it reads FETCH_TIMEOUT-1.
  localparam logic [15:0] WAIT_LAST = 16'(FETCH_TIMEOUT - 1);
  localparam logic [31:0] PC_INC    = 32'(PC_STEP);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        flush_q, flush_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        fetch_enable_q, fetch_enable_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;
  logic        fault_q, fault_d;
  logic        deliver;

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      pc_q           <= RESET_PC;
      flush_q        <= 1'b0;
      wait_cnt_q     <= '0;
      fetch_enable_q <= 1'b0;
      fetch_pc_q     <= RESET_PC;
      ir_q           <= '0;
      ir_pc_q        <= '0;
      ir_valid_q     <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      flush_q        <= flush_d;
      wait_cnt_q     <= wait_cnt_d;
      fetch_enable_q <= fetch_enable_d;
      fetch_pc_q     <= fetch_pc_d;
      ir_q           <= ir_d;
      ir_pc_q        <= ir_pc_d;
      ir_valid_q     <= ir_valid_d;
      fault_q        <= fault_d;
    end
  end

  // Next state, PC, flush flag and WAIT counter; a branch target overrides any increment.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    flush_d    = flush_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_run) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d    = ST_WAIT;
        wait_cnt_d = '0;
      end
      ST_WAIT: begin
        if (i_fetch_completed) begin
          state_d    = ST_CAPTURE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = ST_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      ST_CAPTURE: begin
        if (flush_q || i_branch_valid) begin
          // Word belongs to a stale path: drop it and refetch from pc.
          flush_d = 1'b0;
          state_d = ST_ISSUE;
        end else begin
          pc_d    = pc_q + PC_INC;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (i_ir_ready || i_branch_valid) state_d = i_run ? ST_ISSUE : ST_IDLE;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (i_branch_valid && (state_q != ST_FAULT)) begin
      pc_d = i_branch_target;
      // The bus cycle already started cannot be aborted, so mark its word stale.
      if ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) flush_d = 1'b1;
    end
  end

  // Registered output values and the decoded busy flag.
  always_comb begin
    deliver        = (state_q == ST_CAPTURE) && (state_d == ST_HOLD);
    fetch_enable_d = (state_d == ST_ISSUE);
    fetch_pc_d     = (state_d == ST_ISSUE) ? pc_d : fetch_pc_q;
    ir_d           = deliver ? i_fetch_instruction : ir_q;
    ir_pc_d        = deliver ? pc_q : ir_pc_q;
    ir_valid_d     = (state_d == ST_HOLD);
    fault_d        = fault_q || (state_d == ST_FAULT);
    o_busy         = (state_q != ST_IDLE) && (state_q != ST_FAULT);
  end

  assign o_fetch_enable = fetch_enable_q;
  assign o_fetch_pc     = fetch_pc_q;
  assign o_ir           = ir_q;
  assign o_ir_pc        = ir_pc_q;
  assign o_ir_valid     = ir_valid_q;
  assign o_fault        = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios plus a randomized run. A wishbone-like
// slave answers each request after a chosen latency; a transaction-level
// reference model predicts requests, deliveries and squashes.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_run = 1'b0;
  logic        o_fetch_enable;
  logic [31:0] o_fetch_pc;
  logic [31:0] i_fetch_instruction = '0;
  logic        i_fetch_completed = 1'b0;
  logic        o_ir_valid;
  logic [31:0] o_ir;
  logic [31:0] o_ir_pc;
  logic        i_ir_ready = 1'b0;
  logic        i_branch_valid = 1'b0;
  logic [31:0] i_branch_target = '0;
  logic        o_busy;
  logic        o_fault;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .RESET_PC      (32'h0000_0000),
    .PC_STEP       (4),
    .FETCH_TIMEOUT (8)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .i_run               (i_run),
    .o_fetch_enable      (o_fetch_enable),
    .o_fetch_pc          (o_fetch_pc),
    .i_fetch_instruction (i_fetch_instruction),
    .i_fetch_completed   (i_fetch_completed),
    .o_ir_valid          (o_ir_valid),
    .o_ir                (o_ir),
    .o_ir_pc             (o_ir_pc),
    .i_ir_ready          (i_ir_ready),
    .i_branch_valid      (i_branch_valid),
    .i_branch_target     (i_branch_target),
    .o_busy              (o_busy),
    .o_fault             (o_fault)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_compared++;
    if (obs !== exp_v) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Slave: completion arrives lat WAIT cycles after the first WAIT cycle; its
  // instruction register is updated on the completion edge, junk otherwise.
  int          sl_lat_cfg = -1;
  int          sl_cnt = 0;
  bit          sl_load = 1'b0;
  logic [31:0] sl_word = '0;
  bit          sl_word_fixed = 1'b0;
  logic [31:0] sl_fixed_word = '0;

  task automatic slave_drive();
    i_fetch_completed = 1'b0;
    if (sl_load) begin
      i_fetch_instruction = sl_word;
      sl_load = 1'b0;
    end else begin
      i_fetch_instruction = $urandom;
    end
    if (sl_cnt > 0) begin
      sl_cnt--;
      if (sl_cnt == 0) begin
        i_fetch_completed = 1'b1;
        sl_word = sl_word_fixed ? sl_fixed_word : $urandom;
        sl_load = 1'b1;
      end
    end
    if (o_fetch_enable)
      sl_cnt = ((sl_lat_cfg < 0) ? int'($urandom_range(4, 0)) : sl_lat_cfg) + 1;
  endtask

  // Observation logs and reference model state.
  int          cyc = 0;
  int          last_cmp_cyc = 0;
  bit          prev_valid = 1'b0;
  logic [31:0] fe_log[$];
  logic [31:0] dv_pc_log[$];
  logic [31:0] dv_word_log[$];
  int          dv_cyc_log[$];

  bit          model_en = 1'b0;
  logic [31:0] exp_pc;
  bit          m_issue, m_out, m_cap, m_hold, m_taint;
  logic [31:0] m_addr, m_data;

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hBAD0_BAD0;
  endfunction

  task automatic model_step();
    bit n_issue, n_out, n_cap, n_hold, idle;
    check_val("fetch_enable", 32'(o_fetch_enable), 32'(m_issue));
    if (m_issue) check_val("fetch_pc", o_fetch_pc, exp_pc);
    check_val("ir_valid", 32'(o_ir_valid), 32'(m_hold));
    if (m_hold) begin
      check_val("ir_word", o_ir, m_data);
      check_val("ir_pc", o_ir_pc, m_addr);
    end
    idle = !(m_issue || m_out || m_cap || m_hold);
    check_val("busy", 32'(o_busy), 32'(!idle));
    check_val("no_fault", 32'(o_fault), 32'd0);

    n_issue = 1'b0; n_out = 1'b0; n_cap = 1'b0; n_hold = 1'b0;
    if (m_issue) begin
      n_out   = 1'b1;
      m_addr  = exp_pc;
      m_taint = 1'b0;
    end
    if (m_out) begin
      if (i_fetch_completed) begin
        n_cap  = 1'b1;
        m_data = sl_word;
      end else begin
        n_out = 1'b1;
      end
    end
    if (m_cap) begin
      if (m_taint || i_branch_valid) n_issue = 1'b1;
      else begin
        n_hold = 1'b1;
        exp_pc = m_addr + 32'd4;
      end
    end
    if (m_hold) begin
      if (i_ir_ready || i_branch_valid) n_issue = i_run;
      else n_hold = 1'b1;
    end
    if (idle) n_issue = i_run;
    if (i_branch_valid) begin
      exp_pc = i_branch_target;
      if (m_issue || m_out) m_taint = 1'b1;
    end
    m_issue = n_issue; m_out = n_out; m_cap = n_cap; m_hold = n_hold;
  endtask

  task automatic monitor();
    cyc++;
    if (o_fetch_enable) fe_log.push_back(o_fetch_pc);
    if (o_ir_valid && !prev_valid) begin
      dv_pc_log.push_back(o_ir_pc);
      dv_word_log.push_back(o_ir);
      dv_cyc_log.push_back(cyc);
    end
    if (i_fetch_completed) last_cmp_cyc = cyc;
    prev_valid = o_ir_valid;
    if (model_en) model_step();
  endtask

  task automatic step(input bit run, input bit ready, input bit br, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    slave_drive();
    i_run = run;
    i_ir_ready = ready;
    i_branch_valid = br;
    i_branch_target = tgt;
    @(negedge clk);
    monitor();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_fe"}, 32'(o_fetch_enable), 32'd0);
    check_val({tag, "_valid"}, 32'(o_ir_valid), 32'd0);
    check_val({tag, "_busy"}, 32'(o_busy), 32'd0);
    check_val({tag, "_fault"}, 32'(o_fault), 32'd0);
    check_val({tag, "_ir"}, o_ir, 32'd0);
    check_val({tag, "_ir_pc"}, o_ir_pc, 32'd0);
    check_val({tag, "_fetch_pc"}, o_fetch_pc, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    i_run = 1'b0; i_ir_ready = 1'b0; i_branch_valid = 1'b0; i_branch_target = '0;
    i_fetch_completed = 1'b0;
    sl_cnt = 0; sl_load = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    exp_pc = 32'h0;
    m_issue = 1'b0; m_out = 1'b0; m_cap = 1'b0; m_hold = 1'b0; m_taint = 1'b0;
    fe_log.delete(); dv_pc_log.delete(); dv_word_log.delete(); dv_cyc_log.delete();
    prev_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic run_until(input bit use_fe, input int n, input bit run, input bit ready,
                           input int budget, input string tag);
    int k = 0;
    while (((use_fe ? fe_log.size() : dv_pc_log.size()) < n) && (k < budget)) begin
      step(run, ready, 1'b0, 32'h0);
      k++;
    end
    check_val(tag, 32'((use_fe ? fe_log.size() : dv_pc_log.size()) >= n), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // First fetch: ack two cycles after the request, then a 10-cycle stall in HOLD.
    do_reset();
    model_en = 1'b1;
    sl_lat_cfg = 1; sl_word_fixed = 1'b1; sl_fixed_word = 32'hDEAD_BEEF;
    repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0);
    check_val("t1_fe_count", 32'(fe_log.size()), 32'd1);
    check_val("t1_fe_pc", q_at(fe_log, 0), 32'h0);
    check_val("t1_word", q_at(dv_word_log, 0), 32'hDEAD_BEEF);
    check_val("t1_ir_pc", q_at(dv_pc_log, 0), 32'h0);
    check_val("t1_valid_lat", 32'((dv_cyc_log.size() > 0) ? dv_cyc_log[0] - last_cmp_cyc : -1), 32'd2);
    repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0);
    check_val("t3_no_req", 32'(fe_log.size()), 32'd1);
    check_val("t3_held_valid", 32'(o_ir_valid), 32'd1);
    check_val("t3_held_word", o_ir, 32'hDEAD_BEEF);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_val("t3_fe_after_ready", 32'(o_fetch_enable), 32'd1);
    check_val("t3_fe_pc", o_fetch_pc, 32'h4);
    sl_word_fixed = 1'b0;

    // Three back-to-back fetches with ready held high.
    do_reset();
    sl_lat_cfg = 1;
    run_until(1'b0, 3, 1'b1, 1'b1, 60, "t2_budget");
    check_val("t2_pc0", q_at(dv_pc_log, 0), 32'h0);
    check_val("t2_pc1", q_at(dv_pc_log, 1), 32'h4);
    check_val("t2_pc2", q_at(dv_pc_log, 2), 32'h8);

    // Branch during WAIT: the in-flight word is discarded.
    do_reset();
    sl_lat_cfg = 3;
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h100);
    run_until(1'b0, 1, 1'b1, 1'b1, 40, "t4_budget");
    check_val("t4_refetch_pc", q_at(fe_log, 1), 32'h100);
    check_val("t4_first_valid_pc", q_at(dv_pc_log, 0), 32'h100);

    // PC wrap from the top of the address space.
    do_reset();
    sl_lat_cfg = -1;
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    run_until(1'b1, 2, 1'b1, 1'b1, 40, "wrap_budget");
    check_val("wrap_pc0", q_at(fe_log, 0), 32'hFFFF_FFFC);
    check_val("wrap_pc1", q_at(fe_log, 1), 32'h0);

    // Asynchronous reset in the middle of a WAIT.
    do_reset();
    sl_lat_cfg = 0;
    run_until(1'b0, 1, 1'b1, 1'b1, 20, "aw_first_budget");
    sl_lat_cfg = 1000;
    run_until(1'b1, 2, 1'b1, 1'b1, 20, "aw_second_budget");
    repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0);
    check_val("aw_pre_busy", 32'(o_busy), 32'd1);
    check_val("aw_pre_fetch_pc", o_fetch_pc, 32'h4);
    model_en = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("aw");

    // Timeout: no ack ever arrives.
    do_reset();
    sl_lat_cfg = 1000;
    for (int k = 0; (k < 10) && !o_fetch_enable; k++) step(1'b1, 1'b0, 1'b0, 32'h0);
    check_val("flt_issue", 32'(o_fetch_enable), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check_val("flt_early", 32'(o_fault), 32'd0);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_val("flt_rise", 32'(o_fault), 32'd1);
    check_val("flt_busy", 32'(o_busy), 32'd0);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, 1'($urandom % 2), 32'h200);
      check_val("flt_sticky", 32'(o_fault), 32'd1);
      check_val("flt_no_req", 32'(o_fetch_enable), 32'd0);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_val("flt_cleared", 32'(o_fault), 32'd0);

    // Randomized run against the reference model.
    do_reset();
    model_en = 1'b1;
    sl_lat_cfg = -1;
    for (int k = 0; k < 3000; k++) begin
      step(1'(($urandom % 8) != 0), 1'(($urandom % 3) != 0), 1'(($urandom % 12) == 0),
           $urandom & 32'hFFFF_FFFC);
    end
    check_val("rand_progress", 32'(dv_pc_log.size() > 50), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
